// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target and EX/MEM register, with an iterative shift-add multiplier.
// Optional EX_OVERFLOW_EN adds ex_overflow and suppresses writes of overflowing add/sub.
module ex_stage #(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  instr_bits_15_11,
    input  logic [4:0]  instr_bits_20_16,
    input  logic [31:0] extended_bits,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] new_pc_value,
    input  logic        RegDst,
    input  logic        RegWrite,
    input  logic        ALUSrc,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic        Branch,
    input  logic [1:0]  load_mode,
    input  logic [2:0]  ALUOp,
    output logic        stall,
    output logic [31:0] ex_alu_result,
    output logic [31:0] ex_write_data,
    output logic [4:0]  ex_write_register,
    output logic [31:0] ex_branch_target,
    output logic        ex_zero,
    output logic        ex_RegWrite,
    output logic        ex_MemWrite,
    output logic        ex_MemRead,
    output logic        ex_MemToReg,
    output logic        ex_Branch,
    output logic [1:0]  ex_load_mode
`ifdef EX_OVERFLOW_EN
    ,
    output logic        ex_overflow
`endif
);
    localparam int N = 32 / MUL_STEP;
    localparam logic [5:0] LAST = 6'(N - 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] branch_target;
        logic [4:0]  write_register;
        logic        zero;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        mem_to_reg;
        logic        branch;
        logic [1:0]  load_mode;
        logic        overflow;
    } exmem_t;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] mcand, mplier, acc, step_sum;
    logic [31:0] op_a, op_b, sum, diff, alu_res;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        is_mul, add_ovf, sub_ovf, ovf, bubble;
    exmem_t      nxt, q;

    assign funct   = extended_bits[5:0];
    assign shamt   = extended_bits[10:6];
    assign op_a    = read_data1;
    assign op_b    = ALUSrc ? extended_bits : read_data2;
    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign add_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
    assign sub_ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
    assign is_mul  = (ALUOp == 3'b010) && (funct == 6'h18);
    assign stall   = is_mul && (state != DONE);
    // The mul occupies IDLE (capture) and every BUSY cycle; EX/MEM sees bubbles then.
    assign bubble  = (is_mul && state == IDLE) || state == BUSY;

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (ALUOp)
            3'b000: begin alu_res = sum;  ovf = add_ovf; end
            3'b001: begin alu_res = diff; ovf = sub_ovf; end
            3'b010: begin
                case (funct)
                    6'h20: begin alu_res = sum;  ovf = add_ovf; end
                    6'h22: begin alu_res = diff; ovf = sub_ovf; end
                    6'h24: alu_res = op_a & op_b;
                    6'h25: alu_res = op_a | op_b;
                    6'h2A: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                    6'h00: alu_res = op_b << shamt;
                    6'h02: alu_res = op_b >> shamt;
                    6'h18: alu_res = acc;
                    default: alu_res = '0;
                endcase
            end
            3'b011: alu_res = op_a & op_b;
            3'b100: alu_res = op_a | op_b;
            3'b101: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    // Only the low product word is kept, so the multiplicand never needs more than 32 bits.
    always_comb begin
        step_sum = acc;
        for (int i = 0; i < MUL_STEP; i++)
            if (mplier[i]) step_sum = step_sum + (mcand << i);
    end

    always_comb begin
        nxt = '0;
        if (!bubble) begin
            nxt.alu_result     = alu_res;
            nxt.write_data     = read_data2;
            nxt.branch_target  = new_pc_value + (extended_bits << 2);
            nxt.write_register = RegDst ? instr_bits_15_11 : instr_bits_20_16;
            nxt.zero           = (alu_res == 32'd0);
            nxt.reg_write      = RegWrite;
            nxt.mem_write      = MemWrite;
            nxt.mem_read       = MemRead;
            nxt.mem_to_reg     = MemToReg;
            nxt.branch         = Branch;
            nxt.load_mode      = load_mode;
`ifdef EX_OVERFLOW_EN
            nxt.overflow       = ovf;
            if (ovf) begin
                nxt.reg_write = 1'b0;
                nxt.mem_write = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            q      <= '0;
        end else begin
            q <= nxt;
            case (state)
                IDLE: if (is_mul) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= BUSY;
                end
                BUSY: begin
                    acc    <= step_sum;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + 6'd1;
                    if (cnt == LAST) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ex_alu_result     = q.alu_result;
    assign ex_write_data     = q.write_data;
    assign ex_write_register = q.write_register;
    assign ex_branch_target  = q.branch_target;
    assign ex_zero           = q.zero;
    assign ex_RegWrite       = q.reg_write;
    assign ex_MemWrite       = q.mem_write;
    assign ex_MemRead        = q.mem_read;
    assign ex_MemToReg       = q.mem_to_reg;
    assign ex_Branch         = q.branch;
    assign ex_load_mode      = q.load_mode;
`ifdef EX_OVERFLOW_EN
    assign ex_overflow       = q.overflow;
`else
    logic unused_ovf;
    assign unused_ovf = ovf ^ q.overflow;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage (MUL_STEP=1): ALU ops, branch target, iterative mul, resets, overflow.
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  rd, rt;
    logic [31:0] ext, rd1, rd2, pc;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
    logic [1:0]  load_mode;
    logic [2:0]  ALUOp;
    logic        stall, ex_zero, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Branch;
    logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
    logic [4:0]  ex_write_register;
    logic [1:0]  ex_load_mode;
`ifdef EX_OVERFLOW_EN
    logic        ex_overflow;
`endif
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    ex_stage #(.MUL_STEP(1)) dut (
        .clk(clk), .rst(rst),
        .instr_bits_15_11(rd), .instr_bits_20_16(rt), .extended_bits(ext),
        .read_data1(rd1), .read_data2(rd2), .new_pc_value(pc),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg), .Branch(Branch),
        .load_mode(load_mode), .ALUOp(ALUOp), .stall(stall),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_write_register(ex_write_register), .ex_branch_target(ex_branch_target),
        .ex_zero(ex_zero), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg), .ex_Branch(ex_Branch),
        .ex_load_mode(ex_load_mode)
`ifdef EX_OVERFLOW_EN
        , .ex_overflow(ex_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clr();
        rd = 0; rt = 0; ext = 0; rd1 = 0; rd2 = 0; pc = 0;
        RegDst = 0; RegWrite = 0; ALUSrc = 0; MemWrite = 0; MemRead = 0;
        MemToReg = 0; Branch = 0; load_mode = 0; ALUOp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_op(input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
        clr();
        ALUOp = 3'b010; ext = {21'd0, sh, fn}; rd1 = a; rd2 = b;
        RegDst = 1; rd = 5'd3; RegWrite = 1;
        step();
        check(tag, ex_alu_result, exp);
    endtask

    // Applies a mul (rd=12) and follows it through the stalled cycles to the result edge.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc = 0, bad = 0;
        clr();
        ALUOp = 3'b010; ext = 32'h18; rd1 = a; rd2 = b; RegDst = 1; rd = 5'd12; RegWrite = 1;
        #1;
        while (stall && cyc < 100) begin
            step();
            cyc++;
            if (ex_RegWrite || ex_MemWrite || ex_Branch) bad++;
        end
        check("mul_stall_cycles", cyc, 33);
        check("mul_bubbles", bad, 0);
        check("mul_done_stall", {31'd0, stall}, 0);
        step();
        check("mul_result", ex_alu_result, exp);
        check("mul_regwrite", {31'd0, ex_RegWrite}, 1);
        check("mul_zero", {31'd0, ex_zero}, {31'd0, exp == 32'd0});
        check("mul_wreg", {27'd0, ex_write_register}, 12);
    endtask

    initial begin
        clr();
        #2;
        check("rst_result", ex_alu_result, 0);
        check("rst_regwrite", {31'd0, ex_RegWrite}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        @(negedge clk);
        rst = 0;

        // R-type add wrapping to zero
        clr();
        ALUOp = 3'b010; ext = 32'h20; rd1 = 7; rd2 = 32'hFFFFFFF9; RegDst = 1; rd = 5; rt = 9; RegWrite = 1;
        step();
        check("radd_result", ex_alu_result, 0);
        check("radd_zero", {31'd0, ex_zero}, 1);
        check("radd_wreg", {27'd0, ex_write_register}, 5);
        check("radd_regwrite", {31'd0, ex_RegWrite}, 1);

        // asynchronous reset mid-stream
        rst = 1;
        #2;
        check("arst_result", ex_alu_result, 0);
        check("arst_regwrite", {31'd0, ex_RegWrite}, 0);
        check("arst_wreg", {27'd0, ex_write_register}, 0);
        @(negedge clk);
        rst = 0;

        // beq-class subtract and branch target
        clr();
        ALUOp = 3'b001; Branch = 1; pc = 32'h100; ext = 32'hFFFFFFFE; rd1 = 3; rd2 = 3;
        step();
        check("beq_target", ex_branch_target, 32'hF8);
        check("beq_branch", {31'd0, ex_Branch}, 1);
        check("beq_zero", {31'd0, ex_zero}, 1);
        check("beq_regwrite", {31'd0, ex_RegWrite}, 0);

        // addi with immediate operand, rt destination
        clr();
        ALUOp = 3'b000; ALUSrc = 1; rd1 = 32'h10; ext = 32'hFFFFFFFF; rt = 9; rd = 4; RegWrite = 1;
        step();
        check("addi_result", ex_alu_result, 32'hF);
        check("addi_wreg", {27'd0, ex_write_register}, 9);

        // store-like: pass-through fields
        clr();
        ALUOp = 3'b000; ALUSrc = 1; rd1 = 32'h1000; ext = 8; rd2 = 32'hDEADBEEF;
        MemWrite = 1; MemRead = 1; MemToReg = 1; load_mode = 2'b10;
        step();
        check("sw_result", ex_alu_result, 32'h1008);
        check("sw_wdata", ex_write_data, 32'hDEADBEEF);
        check("sw_memwrite", {31'd0, ex_MemWrite}, 1);
        check("sw_ctrl", {29'd0, ex_MemRead, ex_MemToReg, ex_Branch}, 3'b110);
        check("sw_loadmode", {30'd0, ex_load_mode}, 2);

        clr(); ALUOp = 3'b011; rd1 = 32'hF0F0; rd2 = 32'hFF00; step();
        check("and_op", ex_alu_result, 32'hF000);
        clr(); ALUOp = 3'b100; rd1 = 32'hF0F0; rd2 = 32'hFF00; step();
        check("or_op", ex_alu_result, 32'hFFF0);
        clr(); ALUOp = 3'b101; rd1 = 32'hFFFFFFFF; rd2 = 1; step();
        check("slti_signed", ex_alu_result, 1);
        clr(); ALUOp = 3'b110; rd1 = 5; rd2 = 6; step();
        check("aluop110", ex_alu_result, 0);
        check("aluop110_zero", {31'd0, ex_zero}, 1);
        clr(); ALUOp = 3'b111; rd1 = 5; rd2 = 6; step();
        check("aluop111", ex_alu_result, 0);

        r_op(6'h22, 5'd0, 32'd5, 32'd9, 32'hFFFFFFFC, "r_sub");
        r_op(6'h24, 5'd0, 32'hC, 32'hA, 32'h8, "r_and");
        r_op(6'h25, 5'd0, 32'hC, 32'hA, 32'hE, "r_or");
        r_op(6'h2A, 5'd0, 32'd5, 32'hFFFFFFFD, 32'd0, "r_slt_pos");
        r_op(6'h2A, 5'd0, 32'h80000000, 32'd1, 32'd1, "r_slt_neg");
        r_op(6'h00, 5'd4, 32'd0, 32'd1, 32'h10, "r_sll");
        r_op(6'h02, 5'd8, 32'd0, 32'h80000000, 32'h00800000, "r_srl");
        r_op(6'h3F, 5'd0, 32'd3, 32'd4, 32'd0, "r_unknown");

        // multiplies, back to back
        do_mul(32'h10000, 32'h30001, 32'h00010000);
        do_mul(32'd6, 32'd7, 32'd42);
        do_mul(32'h10000, 32'h10000, 32'd0);

        // reset while busy at count 10
        clr();
        ALUOp = 3'b010; ext = 32'h18; rd1 = 32'd3; rd2 = 32'd5; RegDst = 1; rd = 5'd12; RegWrite = 1;
        step();
        repeat (10) step();
        check("busy_stall", {31'd0, stall}, 1);
        rst = 1;
        clr();
        #2;
        check("busy_rst_regwrite", {31'd0, ex_RegWrite}, 0);
        check("busy_rst_result", ex_alu_result, 0);
        check("busy_rst_stall", {31'd0, stall}, 0);
        @(negedge clk);
        rst = 0;
        step();
        check("post_rst_regwrite", {31'd0, ex_RegWrite}, 0);
        check("post_rst_result", ex_alu_result, 0);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);

        // signed overflow on add
        clr();
        ALUOp = 3'b000; rd1 = 32'h7FFFFFFF; rd2 = 1; RegWrite = 1; MemWrite = 1;
        step();
        check("ovf_result", ex_alu_result, 32'h80000000);
`ifdef EX_OVERFLOW_EN
        check("ovf_flag", {31'd0, ex_overflow}, 1);
        check("ovf_regwrite", {31'd0, ex_RegWrite}, 0);
        check("ovf_memwrite", {31'd0, ex_MemWrite}, 0);
        clr(); ALUOp = 3'b001; rd1 = 32'h80000000; rd2 = 1; RegWrite = 1; step();
        check("ovf_sub_flag", {31'd0, ex_overflow}, 1);
        clr(); ALUOp = 3'b000; rd1 = 32'd1; rd2 = 32'd2; RegWrite = 1; step();
        check("noovf_flag", {31'd0, ex_overflow}, 0);
        check("noovf_regwrite", {31'd0, ex_RegWrite}, 1);
`else
        check("ovf_regwrite", {31'd0, ex_RegWrite}, 1);
        check("ovf_memwrite", {31'd0, ex_MemWrite}, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; the consumer end of the ID/EX stage register.
- Decodes ALUOp/funct, selects operands, computes ALU result and branch target, and registers everything into the EX/MEM stage register.
- Multiplies run on an iterative shift-add unit. While it is busy, the block raises `stall` back toward the fetch/decode stages.

Parameters:
- MUL_STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8; iteration count N = 32/MUL_STEP

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_bits_15_11  in  5  rd field
- instr_bits_20_16  in  5  rt field
- extended_bits  in  32  sign-extended immediate; [5:0] = funct, [10:6] = shamt
- read_data1  in  32  rs value
- read_data2  in  32  rt value
- new_pc_value  in  32  PC+4
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch  in  1 each  control bits from decode
- load_mode  in  2  load width code, passed through
- ALUOp  in  3  ALU operation class
- stall  out  1  combinational; upstream holds all ID/EX inputs stable while high
- ex_alu_result  out  32  registered
- ex_write_data  out  32  registered read_data2
- ex_write_register  out  5  registered destination register
- ex_branch_target  out  32  registered new_pc_value + (extended_bits<<2), mod 2^32
- ex_zero  out  1  registered (ALU result == 0)
- ex_RegWrite, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Branch  out  1 each  registered controls
- ex_load_mode  out  2  registered

Behaviour:
- Reset: all ex_* outputs are 0; FSM goes to IDLE; multiplier count and accumulator are cleared. Reset mid-multiply aborts the operation with no write.
- Operand B = ALUSrc ? extended_bits : read_data2.
- Destination = RegDst ? instr_bits_15_11 : instr_bits_20_16.
- ALUOp decode:
  - 000 add
  - 001 sub
  - 010 R-type by funct
  - 011 and
  - 100 or
  - 101 slt (signed)
  - 110/111 result 0
- R-type funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed)
  - 0x00 sll B by shamt, 0x02 srl B by shamt
  - 0x18 mul (iterative, low 32 bits of the product)
  - any other funct: result 0
- Add/sub wrap modulo 2^32; no trap.
- Non-mul instructions: 1-cycle latency; EX/MEM updates on every rising edge; stall=0.
- is_mul = (ALUOp==010 && funct==0x18).
- FSM:
  - IDLE: when is_mul, capture A and B, clear accumulator and count, go to BUSY. The EX/MEM register loads a bubble: all ex_* controls 0; data fields don't-care, driven 0.
  - BUSY: each cycle retires MUL_STEP bits of B. After N cycles go to DONE. A bubble is loaded each cycle.
  - DONE: EX/MEM loads the product with the captured controls; go to IDLE.
- stall = is_mul && state != DONE.
- Multiply occupancy is N+1 stalled cycles plus 1 result cycle.
- Back-to-back muls: the second mul is seen in IDLE on the cycle after DONE and restarts normally.
- ex_zero is computed from the final result, including the mul product.
- Bubbles never assert ex_RegWrite, ex_MemWrite or ex_Branch.

Optional Feature:
- EX_OVERFLOW_EN:
  - When defined: adds output port ex_overflow (1-bit, registered, reset 0). It is set on signed overflow of add/sub, for ALUOp 000/001 and funct 0x20/0x22.
  - An overflowing instruction has ex_RegWrite and ex_MemWrite forced to 0 in the EX/MEM register.
- When undefined: the port is absent; overflow is ignored and the wrapped result is written.

Test Plan:
- Reset then idle: rst=1 mid-stream -> all ex_* = 0 immediately (asynchronous); stall=0.
- R-type add, RegDst=1, rd=5, A=7, B=0xFFFFFFF9 -> next edge ex_alu_result=0, ex_zero=1, ex_write_register=5, ex_RegWrite=1.
- beq-class ALUOp=001, new_pc_value=0x100, imm=0xFFFFFFFE -> ex_branch_target=0xF8, ex_Branch=1; A=B=3 gives ex_zero=1.
- mul, MUL_STEP=1, A=0x10000, B=0x30001 -> stall high for 33 cycles, ex_RegWrite=0 during those cycles; next edge ex_alu_result=0x00010000 (low word of 0x3_0001_0000); stall=0.
- rst asserted during BUSY at count 10 -> FSM IDLE, no product written, ex_RegWrite=0.
- EX_OVERFLOW_EN build: add 0x7FFFFFFF + 1 -> ex_alu_result=0x80000000, ex_overflow=1, ex_RegWrite=0. Same stimulus without the macro -> ex_RegWrite=1.
